// File: rtl/tow_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tow_push_arbiter
// Description : Push-button arbiter and round sequencer for the tug-of-war
//               game. Synchronises the raw buttons, decides who pushed first,
//               emits a one-cycle point (or tie) pulse, holds the dark
//               interval after a point and re-arms only once both buttons
//               have been stably released.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   BLANK_CYCLES : length of the dark interval after a point, in clk cycles
//   DB_CYCLES    : consecutive all-released cycles required before re-arming
//   CW           : width of the shared interval counter
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   pbl   in   raw left push-button (asynchronous, active-high)
//   pbr   in   raw right push-button (asynchronous, active-high)
//   en    in   game active; low forces the arbiter back to WAIT_REL
//   pt_l  out  one-cycle pulse: left won the round
//   pt_r  out  one-cycle pulse: right won the round
//   tie   out  one-cycle pulse: both buttons first seen in the same cycle
//   blank out  high during the dark interval
//   armed out  high while a new press will be accepted
// ============================================================================
module tow_push_arbiter #(
  parameter int BLANK_CYCLES = 4,
  parameter int DB_CYCLES    = 2,
  parameter int CW           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  input  logic en,
  output logic pt_l,
  output logic pt_r,
  output logic tie,
  output logic blank,
  output logic armed
);

  typedef enum logic [1:0] {
    ST_WAIT_REL = 2'd0,
    ST_ARMED    = 2'd1,
    ST_BLANK    = 2'd2
  } state_t;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Synchroniser stages: bit 0 = left, bit 1 = right.
  logic [1:0]    s1_q;
  logic [1:0]    s2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pt_l_q, pt_l_d;
  logic          pt_r_q, pt_r_d;
  logic          tie_q, tie_d;
  logic          blank_q, blank_d;
  logic          armed_q, armed_d;

  logic sl;
  logic sr;

  assign sl = s2_q[0];
  assign sr = s2_q[1];

  // --------------------------------------------------------------------------
  // Two-flop synchroniser for the raw buttons
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= {pbr, pbl};
      s2_q <= s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pt_l_d  = 1'b0;
    pt_r_d  = 1'b0;
    tie_d   = 1'b0;

    case (state_q)
      ST_WAIT_REL: begin
        // Count consecutive cycles with both buttons released and the game
        // enabled; any interruption restarts the count.
        if (!sl && !sr && en) begin
          if (cnt_q == DB_LAST) begin
            state_d = ST_ARMED;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end

      ST_ARMED: begin
        cnt_d = CNT_ZERO;
        // Disable takes precedence so no pulse escapes in the cycle en drops.
        if (!en) begin
          state_d = ST_WAIT_REL;
        end else if (sl && sr) begin
          tie_d   = 1'b1;
          state_d = ST_WAIT_REL;
        end else if (sl) begin
          pt_l_d  = 1'b1;
          state_d = ST_BLANK;
        end else if (sr) begin
          pt_r_d  = 1'b1;
          state_d = ST_BLANK;
        end
      end

      ST_BLANK: begin
        // Buttons are ignored here; a press still held at the end is caught
        // by the release check in WAIT_REL.
        if (!en) begin
          state_d = ST_WAIT_REL;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_WAIT_REL;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_WAIT_REL;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Level outputs are registered copies of the next state so they change
    // on the same edge as the state itself.
    blank_d = (state_d == ST_BLANK);
    armed_d = (state_d == ST_ARMED);
  end

  // --------------------------------------------------------------------------
  // State, counter and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT_REL;
      cnt_q   <= CNT_ZERO;
      pt_l_q  <= 1'b0;
      pt_r_q  <= 1'b0;
      tie_q   <= 1'b0;
      blank_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pt_l_q  <= pt_l_d;
      pt_r_q  <= pt_r_d;
      tie_q   <= tie_d;
      blank_q <= blank_d;
      armed_q <= armed_d;
    end
  end

  assign pt_l  = pt_l_q;
  assign pt_r  = pt_r_q;
  assign tie   = tie_q;
  assign blank = blank_q;
  assign armed = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_tow_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tow_push_arbiter
// Description : Scoreboard bench for tow_push_arbiter. Stimulus pushes the
//               expected output events (pulse highs, blank/armed edges) with
//               the clock edge at which they must appear; a monitor compares
//               every observed event against the head of that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tow_push_arbiter;

  localparam int K_PL  = 0;
  localparam int K_PR  = 1;
  localparam int K_TIE = 2;
  localparam int K_BR  = 3;
  localparam int K_BF  = 4;
  localparam int K_AR  = 5;
  localparam int K_AF  = 6;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  logic pbl;
  logic pbr;
  logic en;
  logic pt_l;
  logic pt_r;
  logic tie;
  logic blank;
  logic armed;

  int  cyc;
  int  total;
  int  bad;
  ev_t exp_q[$];
  logic prev_b;
  logic prev_a;

  tow_push_arbiter #(
    .BLANK_CYCLES(4),
    .DB_CYCLES   (2),
    .CW          (25)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pbl  (pbl),
    .pbr  (pbr),
    .en   (en),
    .pt_l (pt_l),
    .pt_r (pt_r),
    .tie  (tie),
    .blank(blank),
    .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_PL:    return "pt_l";
      K_PR:    return "pt_r";
      K_TIE:   return "tie";
      K_BR:    return "blank_rise";
      K_BF:    return "blank_fall";
      K_AR:    return "armed_rise";
      K_AF:    return "armed_fall";
      default: return "none";
    endcase
  endfunction

  task automatic expect_ev(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Standard decisive point launched by a press driven right after edge c.
  task automatic expect_point(input int k, input int c);
    expect_ev(k,    c + 3);
    expect_ev(K_BR, c + 3);
    expect_ev(K_AF, c + 3);
    expect_ev(K_BF, c + 7);
    expect_ev(K_AR, c + 9);
  endtask

  task automatic check_ev(input int k);
    ev_t e;
    total = total + 1;
    if (exp_q.size() == 0) begin
      bad = bad + 1;
      $display("FAIL event: got %s at edge %0d, required nothing", kname(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        bad = bad + 1;
        $display("FAIL event: got %s at edge %0d, required %s at edge %0d",
                 kname(k), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [4:0] act, input logic [4:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, cyc names the last
  // rising edge. Reset is skipped; its effect is checked directly.
  always @(negedge clk) begin
    if (rst) begin
      prev_b = 1'b0;
      prev_a = 1'b0;
    end else begin
      if (pt_l)              check_ev(K_PL);
      if (pt_r)              check_ev(K_PR);
      if (tie)               check_ev(K_TIE);
      if (blank && !prev_b)  check_ev(K_BR);
      if (!blank && prev_b)  check_ev(K_BF);
      if (armed && !prev_a)  check_ev(K_AR);
      if (!armed && prev_a)  check_ev(K_AF);
      prev_b = blank;
      prev_a = armed;
    end
  end

  // Apply per-cycle button masks, one bit per falling edge.
  task automatic run_vec(input logic [15:0] lm, input logic [15:0] rm, input int n);
    for (int i = 0; i < n; i++) begin
      pbl = lm[i];
      pbr = rm[i];
      @(negedge clk);
    end
    pbl = 1'b0;
    pbr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c;
    total  = 0;
    bad    = 0;
    prev_b = 1'b0;
    prev_a = 1'b0;
    rst = 1'b0;
    pbl = 1'b1;
    pbr = 1'b0;
    en  = 1'b0;

    // Reset asserted while the left button is held.
    #2 rst = 1'b1;
    #1 check_val("reset_outputs", {pt_l, pt_r, tie, blank, armed}, 5'b00000);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Game FSM enables with left still held: must not arm.
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check_val("armed_while_held", {4'b0000, armed}, 5'b00000);
    c = cyc;
    pbl = 1'b0;
    expect_ev(K_AR, c + 4);
    repeat (6) @(negedge clk);

    // Left alone, right alone.
    c = cyc; expect_point(K_PL, c); run_vec(16'h0001, 16'h0000, 12);
    c = cyc; expect_point(K_PR, c); run_vec(16'h0000, 16'h0001, 12);

    // First press wins by one cycle, both directions.
    c = cyc; expect_point(K_PL, c); run_vec(16'h0007, 16'h000E, 12);
    c = cyc; expect_point(K_PR, c); run_vec(16'h000E, 16'h0007, 12);

    // Same-cycle press: tie, no blank, re-arm after release.
    c = cyc;
    expect_ev(K_TIE, c + 3);
    expect_ev(K_AF,  c + 3);
    expect_ev(K_AR,  c + 8);
    run_vec(16'h000F, 16'h000F, 12);

    // Right pulsed mid-blank: ignored.
    c = cyc; expect_point(K_PL, c); run_vec(16'h0001, 16'h0010, 12);

    // Right held past the end of blank: re-arm waits for release.
    c = cyc;
    expect_ev(K_PL, c + 3);
    expect_ev(K_BR, c + 3);
    expect_ev(K_AF, c + 3);
    expect_ev(K_BF, c + 7);
    expect_ev(K_AR, c + 14);
    run_vec(16'h0001, 16'h03F0, 16);

    // en dropped during blank.
    c = cyc;
    expect_ev(K_PL, c + 3);
    expect_ev(K_BR, c + 3);
    expect_ev(K_AF, c + 3);
    expect_ev(K_BF, c + 6);
    expect_ev(K_AR, c + 12);
    pbl = 1'b1;
    @(negedge clk);
    pbl = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);

    // Reset in the middle of blank.
    c = cyc;
    expect_ev(K_PL, c + 3);
    expect_ev(K_BR, c + 3);
    expect_ev(K_AF, c + 3);
    pbl = 1'b1;
    @(negedge clk);
    pbl = 1'b0;
    repeat (3) @(negedge clk);
    check_val("blank_before_rst", {4'b0000, blank}, 5'b00001);
    #2 rst = 1'b1;
    #1 check_val("rst_mid_blank", {pt_l, pt_r, tie, blank, armed}, 5'b00000);
    @(negedge clk);
    c = cyc;
    expect_ev(K_AR, c + 2);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Point after the full re-arm.
    c = cyc; expect_point(K_PR, c); run_vec(16'h0000, 16'h0003, 12);

    repeat (4) @(negedge clk);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL leftover: %0d expected events never seen, required 0, first %s at edge %0d",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
